ppu_line_packer: RTL and testbench
==================================

# ppu_line_packer

Packs the PPU's serial 2-bit pixel stream into the two 160-bit bit-plane line buffers consumed by the VGA scan-out stage (HVSync). It has three jobs:
- apply the BGP palette to each pixel;
- collect one full scanline in shadow registers;
- publish the line atomically, tagged with its LY, together with `updateBufferSignal`.

It sits between the PPU pixel pipeline and the VGA frame store, in the pixel clock domain.

## Interface
Parameters:
- `LINE_WIDTH`, 160: pixels per scanline and buffer width.
- `VISIBLE_LINES`, 144: lines with LY ≥ this are ignored.

Ports:
- `pixelClk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `lcdEnable`  in  1  LCDC.7; low forces IDLE and clears `updateBufferSignal`.
- `lineStart`  in  1  one-cycle pulse at the start of a PPU line's pixel output.
- `LYIn`  in  8  current LY, sampled on `lineStart`.
- `BGP`  in  8  palette register, sampled on `lineStart`.
- `pixelValid`  in  1  strobe: `pixelColor` is the next pixel, left to right.
- `pixelColor`  in  2  colour index 0–3.
- `LineBuffer0`  out  160  shade bit 0; bit x = screen column x.
- `LineBuffer1`  out  160  shade bit 1; bit x = screen column x.
- `LY`  out  8  line number of the published buffers.
- `updateBufferSignal`  out  1  high once a valid line has been published.
- `lineError`  out  1  sticky: a line was aborted or overrun; cleared by reset only.

## Operation
- States: IDLE, FILL, COMMIT.
- IDLE:
  - `lineStart` with `lcdEnable` = 1 and `LYIn` < 144: latch `LYIn` and `BGP`, set x = 0, go to FILL.
  - `lineStart` with `LYIn` ≥ 144: ignored.
  - `pixelValid` in IDLE: pixel discarded; set `lineError` if it arrives after a COMMIT before the next `lineStart` (overrun).
- FILL, on each `pixelValid`:
  - compute shade = latched BGP[2c+1:2c], where c = `pixelColor`;
  - write shade[0] to shadow0[x] and shade[1] to shadow1[x];
  - x ← x+1.
  - The write with x = 159 moves the state to COMMIT.
- COMMIT (one cycle):
  - `LineBuffer0` ← shadow0, `LineBuffer1` ← shadow1, `LY` ← latched LY;
  - `updateBufferSignal` ← 1;
  - go to IDLE.
- `lineStart` during FILL: the partial line is dropped and `lineError` is set. The new line restarts under the IDLE entry rules.
- Simultaneous `lineStart` and `pixelValid`: `lineStart` wins and the pixel is discarded.
- `lcdEnable` low, any state:
  - next state IDLE;
  - `updateBufferSignal` ← 0;
  - published buffers and `LY` hold their values.
- The published outputs change only in COMMIT. This guarantees they are stable for at least 160 pixel strobes, which exceeds the consumer's 4-cycle capture window.
- The counter x is 8 bits and never exceeds 159. A COMMIT always publishes exactly 160 pixels.

## Timing
- Reset values:
  - `LineBuffer0` = 0, `LineBuffer1` = 0;
  - `LY` = 0;
  - `updateBufferSignal` = 0;
  - `lineError` = 0;
  - state IDLE, x = 0.
- `lineStart` at cycle t → FILL at t+1. The first pixel is accepted from t+1.
- 160th `pixelValid` at cycle p → COMMIT at p+1. New `LineBuffer0`/`LineBuffer1`/`LY` and `updateBufferSignal` are visible at p+2.
- Minimum line time is 162 cycles: `lineStart`, 160 back-to-back pixels, COMMIT. Gaps in `pixelValid` are allowed and add latency only.
- A `lineStart` arriving in the COMMIT cycle is honoured: the commit completes, then FILL begins at the next cycle.
- `reset` has priority over every other input in all states, including mid-FILL and COMMIT.

## Structure
- Shared package `gb_video_pkg`:
  - `LINE_WIDTH` = 160, `VISIBLE_LINES` = 144;
  - state encoding (IDLE = 0, FILL = 1, COMMIT = 2);
  - the DMG default palette constant 8'hE4.
- One sub-module, `bgp_shade_lookup`: combinational mapping of (BGP, colour index) → 2-bit shade. Reused later for OBP0/OBP1.
- The shadow registers, output registers and FSM live in the top module.

## Test plan
- Identity palette: BGP = 8'hE4, LY 5, pixels x%4 for x = 0..159 back-to-back → at p+2, `LineBuffer0` = {40{4'b1010}}, `LineBuffer1` = {40{4'b1100}}, `LY` = 5, `updateBufferSignal` = 1.
- Palette remap: BGP = 8'h1B, all pixels colour 0 → both planes all ones. Then a second line with BGP = 8'hE4 → both planes all zero, and `LY` updates.
- Aborted line: `lineStart` LY 7, 80 pixels, `lineStart` LY 8, 160 pixels → `LY` = 8, `lineError` = 1, the LY 7 data is never published.
- Invisible line: `lineStart` LY 150 + 160 pixels → outputs unchanged, no `updateBufferSignal` rise. An extra pixel after a committed line → `lineError` = 1.
- Gapped stream: `pixelValid` every 3rd cycle → commit exactly 2 cycles after the 160th strobe, and no output change before then.
- Reset and LCD off mid-FILL:
  - `reset` at pixel 100 → all outputs 0 and state IDLE next cycle;
  - `lcdEnable` low → `updateBufferSignal` 0 while buffers hold.

Source files
------------

// File: rtl/ppu_line_packer_pkg.sv
// Shared video definitions for the Game Boy PPU to VGA path: line geometry,
// packer state encoding and palette shade helper.
package gb_video_pkg;

  localparam int LINE_WIDTH    = 160;
  localparam int VISIBLE_LINES = 144;

  // DMG power-on palette: colour index n maps to shade n.
  localparam logic [7:0] DMG_DEFAULT_PALETTE = 8'hE4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } lineState_t;

  function automatic logic [1:0] paletteShade(input logic [7:0] palette,
                                              input logic [1:0] colorIdx);
    return palette[{colorIdx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ppu_line_packer_if.sv
// Pixel stream in / published line buffers out. The PPU side is the master,
// the packer is the slave.
interface ppu_line_packer_if #(
  parameter int LINE_WIDTH = gb_video_pkg::LINE_WIDTH
);
  logic                  lcdEnable;
  logic                  lineStart;
  logic [7:0]            LYIn;
  logic [7:0]            BGP;
  logic                  pixelValid;
  logic [1:0]            pixelColor;
  logic [LINE_WIDTH-1:0] LineBuffer0;
  logic [LINE_WIDTH-1:0] LineBuffer1;
  logic [7:0]            LY;
  logic                  updateBufferSignal;
  logic                  lineError;

  modport master (
    output lcdEnable, lineStart, LYIn, BGP, pixelValid, pixelColor,
    input  LineBuffer0, LineBuffer1, LY, updateBufferSignal, lineError
  );

  modport slave (
    input  lcdEnable, lineStart, LYIn, BGP, pixelValid, pixelColor,
    output LineBuffer0, LineBuffer1, LY, updateBufferSignal, lineError
  );
endinterface

// File: rtl/bgp_shade_lookup.sv
// Combinational palette lookup: colour index to 2-bit shade. Shared by the
// background path and, later, the two object palettes.
module bgp_shade_lookup
  import gb_video_pkg::*;
(
  input  logic [7:0] palette,
  input  logic [1:0] colorIdx,
  output logic [1:0] shade
);

  assign shade = paletteShade(palette, colorIdx);

endmodule

// File: rtl/ppu_line_packer.sv
// Collects one scanline of palette-mapped pixels into shadow planes and
// publishes both planes plus LY atomically in a single COMMIT cycle.
module ppu_line_packer
  import gb_video_pkg::*;
#(
  parameter int LINE_WIDTH    = gb_video_pkg::LINE_WIDTH,
  parameter int VISIBLE_LINES = gb_video_pkg::VISIBLE_LINES
) (
  input  logic               pixelClk,
  input  logic               reset,
  ppu_line_packer_if.slave   bus
);

  localparam logic [7:0] VISIBLE_LIMIT = 8'(VISIBLE_LINES);
  localparam logic [7:0] LAST_X        = 8'(LINE_WIDTH - 1);

  lineState_t            stateReg, stateNext;
  logic [7:0]            xReg;
  logic [7:0]            lyLatchReg;
  logic [7:0]            bgpLatchReg;
  logic [LINE_WIDTH-1:0] shadow0Reg, shadow1Reg;
  logic [LINE_WIDTH-1:0] lineBuf0Reg, lineBuf1Reg;
  logic [7:0]            lyOutReg;
  logic                  updateReg;
  logic                  lineErrorReg;
  logic                  committedReg;

  logic                  lineAccept;
  logic                  latchEn;
  logic                  pixelWe;
  logic                  commitEn;
  logic                  errorSet;
  logic [1:0]            shade;
  logic [LINE_WIDTH-1:0] colSel;

  assign lineAccept = bus.lineStart && bus.lcdEnable && (bus.LYIn < VISIBLE_LIMIT);

  bgp_shade_lookup shadeLookup (
    .palette  (bgpLatchReg),
    .colorIdx (bus.pixelColor),
    .shade    (shade)
  );

  // One-hot column strobe for the shadow write.
  for (genvar gi = 0; gi < LINE_WIDTH; gi++) begin : gen_col_sel
    assign colSel[gi] = pixelWe && (xReg == 8'(gi));
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    if (!bus.lcdEnable) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE: begin
          if (lineAccept) stateNext = FILL;
        end
        FILL: begin
          if (bus.lineStart) begin
            stateNext = lineAccept ? FILL : IDLE;
          end else if (bus.pixelValid && (xReg == LAST_X)) begin
            stateNext = COMMIT;
          end
        end
        COMMIT: begin
          stateNext = lineAccept ? FILL : IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // lineStart always beats a coincident pixel, so pixelWe is only raised
  // when no new line is being announced.
  always_comb begin
    latchEn  = 1'b0;
    pixelWe  = 1'b0;
    commitEn = 1'b0;
    errorSet = 1'b0;
    if (bus.lcdEnable) begin
      case (stateReg)
        IDLE: begin
          latchEn  = lineAccept;
          errorSet = bus.pixelValid && !bus.lineStart && committedReg;
        end
        FILL: begin
          if (bus.lineStart) begin
            latchEn  = lineAccept;
            errorSet = 1'b1;
          end else begin
            pixelWe = bus.pixelValid;
          end
        end
        COMMIT: begin
          commitEn = 1'b1;
          latchEn  = lineAccept;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      xReg         <= '0;
      lyLatchReg   <= '0;
      bgpLatchReg  <= '0;
      shadow0Reg   <= '0;
      shadow1Reg   <= '0;
      lineBuf0Reg  <= '0;
      lineBuf1Reg  <= '0;
      lyOutReg     <= '0;
      updateReg    <= 1'b0;
      lineErrorReg <= 1'b0;
      committedReg <= 1'b0;
    end else begin
      if (latchEn) begin
        lyLatchReg  <= bus.LYIn;
        bgpLatchReg <= bus.BGP;
        xReg        <= '0;
      end else if (pixelWe) begin
        xReg <= (xReg == LAST_X) ? 8'd0 : xReg + 8'd1;
      end

      shadow0Reg <= (shadow0Reg & ~colSel) | ({LINE_WIDTH{shade[0]}} & colSel);
      shadow1Reg <= (shadow1Reg & ~colSel) | ({LINE_WIDTH{shade[1]}} & colSel);

      if (commitEn) begin
        lineBuf0Reg <= shadow0Reg;
        lineBuf1Reg <= shadow1Reg;
        lyOutReg    <= lyLatchReg;
      end

      if (!bus.lcdEnable) begin
        updateReg <= 1'b0;
      end else if (commitEn) begin
        updateReg <= 1'b1;
      end

      if (errorSet) lineErrorReg <= 1'b1;

      // Overrun window: from a commit until the next lineStart of any kind.
      if (bus.lineStart) begin
        committedReg <= 1'b0;
      end else if (commitEn) begin
        committedReg <= 1'b1;
      end
    end
  end

  assign bus.LineBuffer0        = lineBuf0Reg;
  assign bus.LineBuffer1        = lineBuf1Reg;
  assign bus.LY                 = lyOutReg;
  assign bus.updateBufferSignal = updateReg;
  assign bus.lineError          = lineErrorReg;

endmodule

// File: tb/tb_ppu_line_packer.sv
// Directed/randomised bench for ppu_line_packer; expected planes are built
// from the palette rule applied to the pixel list of each line.
module tb_ppu_line_packer;

  logic pixelClk = 1'b0;
  logic reset;

  ppu_line_packer_if bus ();

  ppu_line_packer dut (
    .pixelClk (pixelClk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 pixelClk = ~pixelClk;

  int           testCount = 0;
  int           failCount = 0;
  logic [159:0] expBuf0, expBuf1;
  logic [7:0]   expLy;
  logic         expUpd, expErr;
  int           pix[160];
  logic [159:0] idPlane0, idPlane1, allOnes;

  task automatic tick;
    @(posedge pixelClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, "/LineBuffer0"}, bus.LineBuffer0, expBuf0);
    check({tag, "/LineBuffer1"}, bus.LineBuffer1, expBuf1);
    check({tag, "/LY"}, 160'(bus.LY), 160'(expLy));
    check({tag, "/update"}, 160'(bus.updateBufferSignal), 160'(expUpd));
    check({tag, "/lineError"}, 160'(bus.lineError), 160'(expErr));
  endtask

  task automatic fillRandom;
    for (int i = 0; i < 160; i++) pix[i] = int'($urandom_range(0, 3));
  endtask

  // Reference: shade of column x is bits [2c+1:2c] of the line's palette.
  task automatic modelPublish(input logic [7:0] bgp, input logic [7:0] ly);
    logic [7:0] sh;
    for (int x = 0; x < 160; x++) begin
      sh = bgp >> (2 * pix[x]);
      expBuf0[x] = sh[0];
      expBuf1[x] = sh[1];
    end
    expLy  = ly;
    expUpd = 1'b1;
  endtask

  task automatic startLine(input logic [7:0] ly, input logic [7:0] bgp);
    bus.lineStart = 1'b1;
    bus.LYIn      = ly;
    bus.BGP       = bgp;
    tick;
    bus.lineStart = 1'b0;
  endtask

  task automatic sendPixels(input int first, input int n, input int gap);
    for (int i = first; i < first + n; i++) begin
      bus.pixelValid = 1'b1;
      bus.pixelColor = 2'(pix[i]);
      tick;
      bus.pixelValid = 1'b0;
      if (i != first + n - 1) repeat (gap) tick;
    end
  endtask

  task automatic fullLine(input string tag, input logic [7:0] ly, input logic [7:0] bgp, input int gap);
    startLine(ly, bgp);
    sendPixels(0, 160, gap);
    checkAll({tag, "@p+1"});
    tick;
    if (ly < 8'd144) modelPublish(bgp, ly);
    checkAll({tag, "@p+2"});
    $display("[TB] line %s LY=%0d BGP=%h gap=%0d", tag, ly, bgp, gap);
  endtask

  initial begin
    bus.lcdEnable  = 1'b1;
    bus.lineStart  = 1'b0;
    bus.LYIn       = '0;
    bus.BGP        = '0;
    bus.pixelValid = 1'b0;
    bus.pixelColor = '0;
    reset          = 1'b1;
    expBuf0 = '0; expBuf1 = '0; expLy = '0; expUpd = 1'b0; expErr = 1'b0;
    idPlane0 = {40{4'b1010}};
    idPlane1 = {40{4'b1100}};
    allOnes  = '1;
    repeat (3) tick;
    reset = 1'b0;
    checkAll("reset");

    // Identity palette, colour x%4.
    for (int i = 0; i < 160; i++) pix[i] = i % 4;
    fullLine("identity", 8'd5, 8'hE4, 0);
    check("identity/plane0const", bus.LineBuffer0, idPlane0);
    check("identity/plane1const", bus.LineBuffer1, idPlane1);

    // Palette remap, then identity with all colour 0.
    for (int i = 0; i < 160; i++) pix[i] = 0;
    fullLine("remap1B", 8'd20, 8'h1B, 0);
    check("remap1B/plane0ones", bus.LineBuffer0, allOnes);
    fullLine("remapE4", 8'd21, 8'hE4, 0);

    // Random lines.
    for (int n = 0; n < 3; n++) begin
      fillRandom;
      fullLine("random", 8'($urandom_range(0, 143)), 8'($urandom), int'($urandom_range(0, 2)));
    end

    // Aborted line: LY 7 partial, restarted by LY 8.
    fillRandom;
    startLine(8'd7, 8'($urandom));
    sendPixels(0, 80, 0);
    checkAll("abort/beforeRestart");
    fillRandom;
    expErr = 1'b1;
    fullLine("abort", 8'd8, 8'($urandom), 0);

    // Invisible line after reset, then overrun pixel.
    reset = 1'b1; tick; reset = 1'b0;
    expBuf0 = '0; expBuf1 = '0; expLy = '0; expUpd = 1'b0; expErr = 1'b0;
    fillRandom;
    fullLine("invisible", 8'd150, 8'($urandom), 0);
    fillRandom;
    fullLine("visible", 8'd143, 8'($urandom), 1);
    bus.pixelValid = 1'b1; bus.pixelColor = 2'd1;
    tick;
    bus.pixelValid = 1'b0;
    expErr = 1'b1;
    checkAll("overrun");
    $display("[TB] overrun pixel");

    // Gapped stream, pixelValid every 3rd cycle.
    fillRandom;
    fullLine("gapped", 8'($urandom_range(0, 143)), 8'($urandom), 2);

    // Reset asserted with the 100th pixel.
    fillRandom;
    startLine(8'd33, 8'($urandom));
    sendPixels(0, 99, 0);
    bus.pixelValid = 1'b1;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.pixelValid = 1'b0;
    expBuf0 = '0; expBuf1 = '0; expLy = '0; expUpd = 1'b0; expErr = 1'b0;
    checkAll("midReset");
    sendPixels(0, 160, 0);
    tick; tick;
    checkAll("midReset/idle");
    $display("[TB] reset mid-FILL");

    // LCD off mid-FILL.
    fillRandom;
    fullLine("preLcdOff", 8'd60, 8'($urandom), 0);
    startLine(8'd61, 8'($urandom));
    sendPixels(0, 50, 0);
    bus.lcdEnable = 1'b0;
    tick;
    expUpd = 1'b0;
    checkAll("lcdOff");
    bus.lcdEnable = 1'b1;
    sendPixels(50, 110, 0);
    tick; tick;
    checkAll("lcdOff/idle");
    $display("[TB] LCD off mid-FILL");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
